// File: rtl/ftdi_cmd_decode_if.sv
// ftdi_cmd_decode_if: rx/tx byte streams and 32-bit memory bus seen by the command decoder
interface ftdi_cmd_decode_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_accept;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_accept;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_wr;
    logic        mem_wr;
    logic        mem_rd;
    logic        mem_accept;
    logic        mem_ack;
    logic [31:0] mem_data_rd;

    modport master (
        input  rx_valid, rx_data, tx_accept, mem_accept, mem_ack, mem_data_rd,
        output rx_accept, tx_valid, tx_data, mem_addr, mem_data_wr, mem_wr, mem_rd
    );

    modport slave (
        output rx_valid, rx_data, tx_accept, mem_accept, mem_ack, mem_data_rd,
        input  rx_accept, tx_valid, tx_data, mem_addr, mem_data_wr, mem_wr, mem_rd
    );
endinterface

// File: rtl/ftdi_cmd_decode.sv
// ftdi_cmd_decode: framed read/write command parser issuing single-outstanding 32-bit bus cycles; define FTDI_CMD_WRITE_RESP_EN for a 0xA5 write acknowledge byte
module ftdi_cmd_decode #(
    parameter int TIMEOUT_W = 16
) (
    input logic               clk_i,
    input logic               rst_i,
    ftdi_cmd_decode_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, LEN, ADDR, DATA, WRITE, WACK, READ, RACK, TX
`ifdef FTDI_CMD_WRITE_RESP_EN
        , RESP
`endif
    } state_t;

`ifdef FTDI_CMD_WRITE_RESP_EN
    localparam state_t WR_END = RESP;
`else
    localparam state_t WR_END = IDLE;
`endif

    localparam logic [7:0]           CMD_WR  = 8'h10;
    localparam logic [7:0]           CMD_RD  = 8'h11;
    localparam logic [TIMEOUT_W-1:0] TMO_ONE = 1;

    state_t               state_q, state_n;
    logic                 cmd_wr_q, cmd_wr_n;
    logic [7:0]           len_q, len_n;
    logic [1:0]           idx_q, idx_n;
    logic [31:0]          addr_q, addr_n;
    logic [31:0]          wdata_q, wdata_n;
    logic [31:0]          rdata_q, rdata_n;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_n;
    logic                 ack_q, ack_n;
    logic                 mem_wr_q, mem_wr_n;
    logic                 mem_rd_q, mem_rd_n;
    logic                 tx_valid_q, tx_valid_n;
    logic [7:0]           tx_data_q, tx_data_n;
    logic                 rx_fire;
    logic                 parsing;
    logic                 ack_seen;

    assign bus.rx_accept   = !rst_i && (state_q == IDLE || parsing);
    assign bus.tx_valid    = tx_valid_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_data_wr = wdata_q;
    assign bus.mem_wr      = mem_wr_q;
    assign bus.mem_rd      = mem_rd_q;

    assign parsing  = state_q == LEN || state_q == ADDR || state_q == DATA;
    assign rx_fire  = bus.rx_valid && bus.rx_accept;
    assign ack_seen = bus.mem_ack || ack_q;

    // Next state, datapath updates and registered-output values
    always_comb begin
        state_n  = state_q;
        cmd_wr_n = cmd_wr_q;
        len_n    = len_q;
        idx_n    = idx_q;
        addr_n   = addr_q;
        wdata_n  = wdata_q;
        rdata_n  = rdata_q;
        tmo_n    = '0;
        ack_n    = (state_q == WRITE || state_q == READ) && bus.mem_accept && bus.mem_ack;
        case (state_q)
            IDLE: if (rx_fire && (bus.rx_data == CMD_WR || bus.rx_data == CMD_RD)) begin
                cmd_wr_n = bus.rx_data == CMD_WR;
                state_n  = LEN;
            end
            LEN: if (rx_fire) begin
                len_n   = bus.rx_data;
                idx_n   = 2'd0;
                state_n = ADDR;
            end
            ADDR: if (rx_fire) begin
                addr_n = {addr_q[23:0], bus.rx_data};
                idx_n  = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    addr_n[1:0] = 2'b00;
                    state_n     = len_q == 8'd0 ? (cmd_wr_q ? WR_END : IDLE) : (cmd_wr_q ? DATA : READ);
                end
            end
            DATA: if (rx_fire) begin
                wdata_n = {wdata_q[23:0], bus.rx_data};
                idx_n   = idx_q + 2'd1;
                state_n = idx_q == 2'd3 ? WRITE : DATA;
            end
            WRITE: state_n = bus.mem_accept ? WACK : WRITE;
            WACK: if (ack_seen) begin
                len_n   = len_q - 8'd1;
                addr_n  = addr_q + 32'd4;
                state_n = len_q == 8'd1 ? WR_END : DATA;
            end
            READ: state_n = bus.mem_accept ? RACK : READ;
            RACK: if (ack_seen) begin
                rdata_n = bus.mem_data_rd;
                idx_n   = 2'd0;
                state_n = TX;
            end
            TX: if (bus.tx_accept) begin
                rdata_n = {rdata_q[23:0], 8'h00};
                idx_n   = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    len_n   = len_q - 8'd1;
                    addr_n  = addr_q + 32'd4;
                    state_n = len_q == 8'd1 ? IDLE : READ;
                end
            end
`ifdef FTDI_CMD_WRITE_RESP_EN
            RESP: state_n = bus.tx_accept ? IDLE : RESP;
`endif
            default: state_n = IDLE;
        endcase
        if (parsing && !rx_fire) begin
            tmo_n = tmo_q + TMO_ONE;
            if (&tmo_q) begin
                tmo_n   = '0;
                state_n = IDLE;
            end
        end
        mem_wr_n   = state_n == WRITE;
        mem_rd_n   = state_n == READ;
        tx_valid_n = state_n == TX;
        tx_data_n  = tx_valid_n ? rdata_n[31:24] : 8'h00;
`ifdef FTDI_CMD_WRITE_RESP_EN
        if (state_n == RESP) begin
            tx_valid_n = 1'b1;
            tx_data_n  = 8'hA5;
        end
`endif
    end

    // State and output registers; reset drops any pending request at once
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cmd_wr_q   <= 1'b0;
            len_q      <= 8'd0;
            idx_q      <= 2'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            tmo_q      <= '0;
            ack_q      <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_rd_q   <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'd0;
        end else begin
            state_q    <= state_n;
            cmd_wr_q   <= cmd_wr_n;
            len_q      <= len_n;
            idx_q      <= idx_n;
            addr_q     <= addr_n;
            wdata_q    <= wdata_n;
            rdata_q    <= rdata_n;
            tmo_q      <= tmo_n;
            ack_q      <= ack_n;
            mem_wr_q   <= mem_wr_n;
            mem_rd_q   <= mem_rd_n;
            tx_valid_q <= tx_valid_n;
            tx_data_q  <= tx_data_n;
        end
    end
endmodule

// File: doc/ftdi_cmd_decode.md
Name: ftdi_cmd_decode

Overview:
Protocol engine that sits directly downstream of the FTDI async FIFO interface. It consumes the received byte stream (outport valid/accept), parses framed read/write commands, and issues single-outstanding 32-bit memory-mapped bus transactions. Read data is serialised back into the FIFO interface's transmit byte stream (inport valid/accept).

Parameters:
TIMEOUT_W, 16, width of inter-byte timeout counter; a partial frame idle for 2^TIMEOUT_W-1 cycles is aborted.

Ports:
clk_i  input  1  clock
rst_i  input  1  reset, asynchronous, active-high
rx_valid_i  input  1  received byte valid (from FIFO interface outport_valid_o)
rx_data_i  input  8  received byte
rx_accept_o  output  1  byte consumed this cycle
tx_valid_o  output  1  transmit byte valid (to FIFO interface inport_valid_i)
tx_data_o  output  8  transmit byte
tx_accept_i  input  1  transmit byte taken
mem_addr_o  output  32  bus address, word aligned
mem_data_wr_o  output  32  bus write data
mem_wr_o  output  1  write request, held until mem_accept_i
mem_rd_o  output  1  read request, held until mem_accept_i
mem_accept_i  input  1  request accepted
mem_ack_i  input  1  response (write done / read data valid)
mem_data_rd_i  input  32  read data, valid with mem_ack_i

Behaviour:
- Frame: CMD, LEN, ADDR[31:24], ADDR[23:16], ADDR[15:8], ADDR[7:0], then for writes 4*LEN data bytes, each word MSB first. CMD 0x10 = write, 0x11 = read. LEN = word count, 1..255; LEN 0 completes after the address with no bus access.
- Byte handshake: a transfer occurs when valid & accept are both high. rx_accept_o is high only in states CMD/LEN/ADDR/DATA. It is combinationally driven from state.
- Unknown CMD byte: consumed and dropped; stay in IDLE. No response.
- States:
  - IDLE(CMD) -> LEN -> ADDR (4 bytes, counted by idx[1:0])
  - ADDR -> DATA (write) / READ (read) / IDLE (LEN=0)
  - DATA: after the 4th byte -> WRITE
  - WRITE: mem_wr_o=1 until accept -> WACK
  - WACK: on mem_ack_i, decrement the word count and add 4 to the address; -> DATA if words remain, else IDLE
  - READ: mem_rd_o=1 until accept -> RACK
  - RACK: on mem_ack_i, capture data -> TX
  - TX: send 4 bytes MSB first; after the 4th is accepted, decrement count, add 4 to address; -> READ or IDLE
- Address: low 2 bits of the received address are forced to 0. The increment wraps modulo 2^32.
- Requests are registered and never asserted together. Address and data are stable while a request is pending.
- mem_ack_i outside WACK/RACK is ignored. An ack in the same cycle as accept is legal: the FSM moves straight through WACK/RACK on the next cycle, using the registered ack.
- Timeout: the counter clears on every accepted rx byte and counts only in LEN/ADDR/DATA. At all-ones the parser returns to IDLE and partial data is discarded. The counter does not run while a bus or tx phase is pending.
- tx_valid_o is registered and held, with tx_data_o stable, until tx_accept_i.
- Reset values: all outputs 0; FSM IDLE; counters 0.
- Reset mid-transaction abandons the bus request immediately. The bus side is expected to share the reset.

Optional Feature:
FTDI_CMD_WRITE_RESP_EN:
- Defined: after the final write ack of a write frame (including LEN=0 writes), enter RESP and emit one tx byte 0xA5, then return to IDLE.
- Undefined: writes are silent, and the RESP state and its logic are absent.

Test Plan:
- Write 1 word: rx 10 01 00 00 10 00 DE AD BE EF -> one mem_wr_o, addr 0x00001000, data 0xDEADBEEF. With FTDI_CMD_WRITE_RESP_EN, also tx 0xA5.
- Read 2 words: rx 11 02 00 00 20 03 -> reads at 0x2000 then 0x2004. Read data 0x01234567, 0x89ABCDEF gives tx 01 23 45 67 89 AB CD EF in order.
- Back-pressure: hold tx_accept_i low 10 cycles mid-read and delay mem_accept_i/mem_ack_i 5 cycles -> tx_data_o and mem_addr_o stable, no extra requests, no byte lost.
- Garbage/LEN0: rx 55 then 10 00 00 00 00 00 then a valid read -> 0x55 dropped, no bus access for the LEN0 frame, read served normally.
- Timeout: rx 10 01 00, then idle 2^TIMEOUT_W cycles (TIMEOUT_W=4 in bench), then a full read frame -> the partial write is discarded and the read executes at the correct address.
- Wrap/reset: write LEN=2 at 0xFFFFFFFC -> second write at 0x00000000. Assert rst_i during WACK -> all outputs 0 next edge, next frame decodes cleanly.
